// File: rtl/grant_lock.sv
// rtl/grant_lock.sv - latches the arbiter's one-hot grant as bus owner and holds it for a counted burst
module grant_lock #(
  parameter int N     = 4,
  parameter int LEN_W = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic [N-1:0]       iGrant,
  input  logic [N*LEN_W-1:0] iLen,
  input  logic               iBeat,
  input  logic               iAbort,
  output logic [N-1:0]       oOwner,
  output logic [IDX_W-1:0]   oOwnerIdx,
  output logic               oValid,
  output logic               oLast,
  output logic [LEN_W-1:0]   oBeatCnt,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state, state_n;
  logic [N-1:0]       owner, owner_n;
  logic [IDX_W-1:0]   owner_idx, owner_idx_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [LEN_W-1:0]   beat_cnt, beat_cnt_n;
  logic               done, done_n;
  logic               error, error_n;

  logic               grant_any;
  logic               grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic               last;

  assign grant_any    = |iGrant;
  assign grant_onehot = grant_any && ((iGrant & (iGrant - N'(1))) == '0);
  assign last         = (state == OWN) && (remaining == '0);

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (iGrant[k]) grant_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= IDLE;
      owner     <= '0;
      owner_idx <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      owner_idx <= owner_idx_n;
      remaining <= remaining_n;
      beat_cnt  <= beat_cnt_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    owner_idx_n = owner_idx;
    remaining_n = remaining;
    beat_cnt_n  = beat_cnt;
    done_n      = 1'b0;
    error_n     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_onehot) begin
          state_n     = OWN;
          owner_n     = iGrant;
          owner_idx_n = grant_idx;
          remaining_n = iLen[grant_idx*LEN_W +: LEN_W];
          beat_cnt_n  = '0;
        end else if (grant_any) begin
          error_n = 1'b1;
        end
      end
      OWN: begin
        // Abort wins over a coincident beat, and the grant is ignored so nothing can steal the bus.
        if (iAbort || (iBeat && last)) begin
          state_n     = IDLE;
          owner_n     = '0;
          owner_idx_n = '0;
          remaining_n = '0;
          beat_cnt_n  = '0;
          done_n      = !iAbort;
        end else if (iBeat) begin
          remaining_n = remaining - LEN_W'(1);
          beat_cnt_n  = beat_cnt + LEN_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign oOwner    = owner;
  assign oOwnerIdx = owner_idx;
  assign oValid    = (state == OWN);
  assign oLast     = last;
  assign oBeatCnt  = beat_cnt;
  assign oBusy     = (state != IDLE);
  assign oDone     = done;
  assign oError    = error;

endmodule

// File: tb/tb_grant_lock.sv
// tb/tb_grant_lock.sv - vector table plus scoreboard bench for grant_lock
module tb_grant_lock;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    grant = '0;
  logic [N*LW-1:0] len = '0;
  logic            beat = 1'b0;
  logic            abort = 1'b0;
  logic [N-1:0]    owner;
  logic [IW-1:0]   owner_idx;
  logic            valid, last, busy, done, error;
  logic [LW-1:0]   beat_cnt;

  grant_lock #(.N(N), .LEN_W(LW), .IDX_W(IW)) dut (
    .iClk(clk), .iRstN(rst_n), .iGrant(grant), .iLen(len), .iBeat(beat), .iAbort(abort),
    .oOwner(owner), .oOwnerIdx(owner_idx), .oValid(valid), .oLast(last),
    .oBeatCnt(beat_cnt), .oBusy(busy), .oDone(done), .oError(error)
  );

  always #5 clk = ~clk;

  // Observed bundle: owner, idx, valid, last, cnt, busy, done, error
  typedef logic [18:0] obs_t;

  typedef struct {
    logic [3:0] grant;
    logic       beat;
    logic       abort;
    obs_t       exp;
    string      name;
  } vec_t;

  vec_t  vecs[$];
  obs_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  obs_t  actual;

  assign actual = {owner, owner_idx, valid, last, beat_cnt, busy, done, error};

  function automatic obs_t ob(logic [3:0] o, logic [1:0] i, logic v, logic l,
                              logic [7:0] c, logic b, logic d, logic e);
    return {o, i, v, l, c, b, d, e};
  endfunction

  function automatic vec_t mk(logic [3:0] g, logic bt, logic ab, obs_t e, string nm);
    vec_t r;
    r.grant = g; r.beat = bt; r.abort = ab; r.exp = e; r.name = nm;
    return r;
  endfunction

  task automatic check(input string name);
    obs_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, actual);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (actual !== e) begin
      n_err++;
      $display("FAIL %s: got own=%b idx=%0d v=%b l=%b cnt=%0d busy=%b done=%b err=%b, required own=%b idx=%0d v=%b l=%b cnt=%0d busy=%b done=%b err=%b",
               name, actual[18:15], actual[14:13], actual[12], actual[11], actual[10:3], actual[2], actual[1], actual[0],
               e[18:15], e[14:13], e[12], e[11], e[10:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic drive(input logic [3:0] g, input logic bt, input logic ab, input obs_t e, input string name);
    @(negedge clk);
    grant = g; beat = bt; abort = ab;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  localparam obs_t ZERO = '0;

  initial begin
    // len[3]=5, len[2]=3, len[1]=2, len[0]=0
    len = {8'd5, 8'd3, 8'd2, 8'd0};
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ZERO);
    check("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "idle"));
    vecs.push_back(mk(4'b0100, 1, 0, ob(4'b0100, 2, 1, 0, 0, 1, 0, 0), "basic_own"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b0100, 2, 1, 0, 1, 1, 0, 0), "basic_b1"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b0100, 2, 1, 0, 2, 1, 0, 0), "basic_b2"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b0100, 2, 1, 1, 3, 1, 0, 0), "basic_last"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b0000, 0, 0, 0, 0, 0, 1, 0), "basic_done"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "basic_idle"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0001, 0, 1, 1, 0, 1, 0, 0), "len0_own1"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0000, 0, 0, 0, 0, 0, 1, 0), "len0_done1"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0001, 0, 1, 1, 0, 1, 0, 0), "len0_own2"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0000, 0, 0, 0, 0, 0, 1, 0), "len0_done2"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "len0_idle"));
    vecs.push_back(mk(4'b0010, 0, 0, ob(4'b0010, 1, 1, 0, 0, 1, 0, 0), "stall_own"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0010, 1, 1, 0, 1, 1, 0, 0), "stall_b1"));
    vecs.push_back(mk(4'b0001, 0, 0, ob(4'b0010, 1, 1, 0, 1, 1, 0, 0), "stall_s1"));
    vecs.push_back(mk(4'b0001, 0, 0, ob(4'b0010, 1, 1, 0, 1, 1, 0, 0), "stall_s2"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0010, 1, 1, 1, 2, 1, 0, 0), "stall_last"));
    vecs.push_back(mk(4'b0001, 1, 0, ob(4'b0000, 0, 0, 0, 0, 0, 1, 0), "stall_done"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "stall_idle"));
    vecs.push_back(mk(4'b0100, 0, 0, ob(4'b0100, 2, 1, 0, 0, 1, 0, 0), "abort_own"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b0100, 2, 1, 0, 1, 1, 0, 0), "abort_b1"));
    vecs.push_back(mk(4'b0000, 1, 1, ZERO, "abort_hit"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "abort_nodone"));
    vecs.push_back(mk(4'b1000, 0, 0, ob(4'b1000, 3, 1, 0, 0, 1, 0, 0), "abort_last_own"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b1000, 3, 1, 0, 1, 1, 0, 0), "abort_last_b1"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b1000, 3, 1, 0, 2, 1, 0, 0), "abort_last_b2"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b1000, 3, 1, 0, 3, 1, 0, 0), "abort_last_b3"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b1000, 3, 1, 0, 4, 1, 0, 0), "abort_last_b4"));
    vecs.push_back(mk(4'b0000, 1, 0, ob(4'b1000, 3, 1, 1, 5, 1, 0, 0), "abort_last_b5"));
    vecs.push_back(mk(4'b0000, 1, 1, ZERO, "abort_on_last"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "abort_on_last_nodone"));
    vecs.push_back(mk(4'b0110, 0, 0, ob(4'b0000, 0, 0, 0, 0, 0, 0, 1), "illegal_err"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "illegal_single"));
    vecs.push_back(mk(4'b1111, 0, 0, ob(4'b0000, 0, 0, 0, 0, 0, 0, 1), "illegal_all"));
    vecs.push_back(mk(4'b0000, 0, 0, ZERO, "illegal_clear"));

    foreach (vecs[i]) drive(vecs[i].grant, vecs[i].beat, vecs[i].abort, vecs[i].exp, vecs[i].name);

    // Reset mid-burst on a 256-beat burst
    len = {8'd255, 8'd3, 8'd2, 8'd0};
    drive(4'b1000, 0, 0, ob(4'b1000, 3, 1, 0, 0, 1, 0, 0), "long_own");
    for (int i = 1; i <= 10; i++)
      drive(4'b0000, 1, 0, ob(4'b1000, 3, 1, 0, 8'(i), 1, 0, 0), "long_beat");
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(ZERO);
    check("async_reset");
    @(posedge clk);
    #1;
    sb.push_back(ZERO);
    check("reset_no_done");
    @(negedge clk);
    rst_n = 1'b1;

    // Full-length burst: count reaches 255 on the last beat without wrapping
    drive(4'b1000, 0, 0, ob(4'b1000, 3, 1, 0, 0, 1, 0, 0), "regrant_own");
    for (int i = 1; i <= 255; i++)
      drive(4'b0000, 1, 0, ob(4'b1000, 3, 1, (i == 255), 8'(i), 1, 0, 0), "max_beat");
    drive(4'b0000, 1, 0, ob(4'b0000, 0, 0, 0, 0, 0, 1, 0), "max_done");
    drive(4'b0000, 0, 0, ZERO, "max_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
